// File: rtl/platform_landing_detector.sv
// Once per frame, scans the platform arrays against a snapshot of the doodle and reports the first landing.
// Optional macro LANDING_SCORE_EN adds a saturating 16-bit landing counter output (score).
module platform_landing_detector #(
    parameter int N_PLAT      = 8,
    parameter int PLAT_HALF_W = 20,
    parameter int PLAT_HALF_H = 4,
    parameter int DOODLE_HALF = 12
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      frame_clk,
    input  logic [9:0]                Doodle_X,
    input  logic [9:0]                Doodle_Y,
    input  logic [9:0]                Doodle_Y_Motion,
    input  logic [9:0]                Platform_X_in [N_PLAT],
    input  logic [9:0]                Platform_Y_in [N_PLAT],
    output logic                      land_valid,
    output logic [$clog2(N_PLAT)-1:0] land_idx,
    output logic [9:0]                land_Y,
    output logic                      scan_done,
    output logic                      busy,
    output logic                      overrun
`ifdef LANDING_SCORE_EN
    ,
    output logic [15:0]               score
`endif
);

    localparam int IDX_W = $clog2(N_PLAT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PLAT - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LATCH  = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    localparam logic [9:0]  REACH_X   = 10'(PLAT_HALF_W + DOODLE_HALF);
    localparam logic [10:0] HALF_H11  = 11'(PLAT_HALF_H);
    localparam logic [10:0] DOODLE11  = 11'(DOODLE_HALF);
    localparam logic [9:0]  SNAP_OFS  = 10'(PLAT_HALF_H + DOODLE_HALF);

    logic [1:0]       state_reg;
    logic             frame_clk_q;
    logic [IDX_W-1:0] idx_reg;
    logic             found_reg;
    logic [IDX_W-1:0] hit_idx_reg;
    logic [9:0]       hit_y_reg;

    logic [9:0] doodle_x_reg;
    logic [9:0] doodle_y_reg;
    logic [9:0] motion_reg;
    logic [9:0] plat_x_reg [N_PLAT];
    logic [9:0] plat_y_reg [N_PLAT];

    logic        start;
    logic [9:0]  cur_px;
    logic [9:0]  cur_py;
    logic [9:0]  dx_abs;
    logic [10:0] bottom;
    logic [10:0] top;
    logic [10:0] reach;
    logic        cur_hit;
    logic [9:0]  cur_y;

    assign start = frame_clk & ~frame_clk_q;
    assign busy  = (state_reg != ST_IDLE);
    assign cur_px = plat_x_reg[idx_reg];
    assign cur_py = plat_y_reg[idx_reg];

    // Hit test on the snapshot; 11-bit sums cannot overflow and top saturates at 0.
    always_comb begin
        dx_abs  = (doodle_x_reg >= cur_px) ? (doodle_x_reg - cur_px) : (cur_px - doodle_x_reg);
        bottom  = {1'b0, doodle_y_reg} + DOODLE11;
        top     = ({1'b0, cur_py} >= HALF_H11) ? ({1'b0, cur_py} - HALF_H11) : 11'd0;
        reach   = top + {1'b0, motion_reg};
        cur_hit = ($signed(motion_reg) > 10'sd0) && (dx_abs <= REACH_X) &&
                  (top <= bottom) && (bottom <= reach);
        cur_y   = cur_py - SNAP_OFS;
    end

    // Snapshot is taken only in LATCH so mid-scan input changes are invisible.
    always_ff @(posedge Clk) begin
        if (state_reg == ST_LATCH) begin
            doodle_x_reg <= Doodle_X;
            doodle_y_reg <= Doodle_Y;
            motion_reg   <= Doodle_Y_Motion;
            for (int i = 0; i < N_PLAT; i++) begin
                plat_x_reg[i] <= Platform_X_in[i];
                plat_y_reg[i] <= Platform_Y_in[i];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg   <= ST_IDLE;
            frame_clk_q <= 1'b0;
            idx_reg     <= '0;
            found_reg   <= 1'b0;
            hit_idx_reg <= '0;
            hit_y_reg   <= '0;
            land_valid  <= 1'b0;
            land_idx    <= '0;
            land_Y      <= '0;
            scan_done   <= 1'b0;
            overrun     <= 1'b0;
`ifdef LANDING_SCORE_EN
            score       <= 16'd0;
`endif
        end else begin
            frame_clk_q <= frame_clk;
            land_valid  <= 1'b0;
            scan_done   <= 1'b0;
            if (start && busy) begin
                overrun <= 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    idx_reg   <= '0;
                    found_reg <= 1'b0;
                    state_reg <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (cur_hit && !found_reg) begin
                        found_reg   <= 1'b1;
                        hit_idx_reg <= idx_reg;
                        hit_y_reg   <= cur_y;
                    end
                    idx_reg <= idx_reg + 1'b1;
                    // Result registers load on the edge into REPORT so the pulses coincide with it.
                    if (idx_reg == LAST_IDX) begin
                        state_reg  <= ST_REPORT;
                        scan_done  <= 1'b1;
                        land_valid <= found_reg | cur_hit;
                        if (found_reg) begin
                            land_idx <= hit_idx_reg;
                            land_Y   <= hit_y_reg;
                        end else if (cur_hit) begin
                            land_idx <= idx_reg;
                            land_Y   <= cur_y;
                        end
`ifdef LANDING_SCORE_EN
                        if ((found_reg | cur_hit) && (score != 16'hFFFF)) begin
                            score <= score + 16'd1;
                        end
`endif
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
